// File: rtl/hex_segment_decoder.sv
// Scanned 7-segment bus monitor: debounces each digit, decodes it back to a
// nibble and hands the assembled word out over a valid/ready handshake.
module hex_segment_decoder #(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel,
  input  logic                    ready,
  output logic                    valid,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    error,
  output logic                    overrun
);

  localparam int SW = 7 + NUM_DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CONE = CW'(1);

  typedef enum logic {
    COLLECT,
    HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           samp_q, samp_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    evt_q, evt_d;
  logic                    valid_q, valid_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   filled_q, filled_d;
  logic                    ovr_q, ovr_d;

  logic                    same;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic                    qual;
  logic                    apply;
  logic [4:0]              dec;

  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    unique case (s)
      7'h40:   r = 5'h00;
      7'h79:   r = 5'h01;
      7'h24:   r = 5'h02;
      7'h30:   r = 5'h03;
      7'h19:   r = 5'h04;
      7'h12:   r = 5'h05;
      7'h02:   r = 5'h06;
      7'h78:   r = 5'h07;
      7'h00:   r = 5'h08;
      7'h10:   r = 5'h09;
      7'h08:   r = 5'h0A;
      7'h03:   r = 5'h0B;
      7'h46:   r = 5'h0C;
      7'h21:   r = 5'h0D;
      7'h06:   r = 5'h0E;
      7'h0E:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  // Debounce: a run of identical samples fires exactly one event.
  always_comb begin
    samp_d = {seg_in, digit_sel};
    same   = (samp_d == samp_q);
    cnt_d  = CONE;
    if (same) begin
      cnt_d = (cnt_q == CMAX) ? cnt_q : cnt_q + CONE;
    end
    evt_d = (cnt_d == CMAX) && !(same && cnt_q == CMAX);
  end

  assign seg_q = samp_q[SW-1:NUM_DIGITS];
  assign sel_q = samp_q[NUM_DIGITS-1:0];
  assign qual  = evt_q && $onehot(sel_q) && (seg_q != 7'h7F);
  assign dec   = decode(seg_q);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    value_d  = value_q;
    err_d    = err_q;
    filled_d = filled_q;
    ovr_d    = ovr_q;
    apply    = 1'b0;
    unique case (state_q)
      COLLECT: begin
        apply = qual;
      end
      HOLD: begin
        if (valid_q && ready) begin
          valid_d  = 1'b0;
          filled_d = '0;
          err_d    = '0;
          ovr_d    = 1'b0;
          state_d  = COLLECT;
          apply    = qual;
        end else if (qual) begin
          ovr_d = 1'b1;
        end
      end
    endcase
    if (apply) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (sel_q[k]) begin
          value_d[4*k +: 4] = dec[3:0];
          err_d[k]          = dec[4];
          filled_d[k]       = 1'b1;
        end
      end
      if (&filled_d) begin
        valid_d = 1'b1;
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= COLLECT;
      samp_q   <= '0;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
      valid_q  <= 1'b0;
      value_q  <= '0;
      err_q    <= '0;
      filled_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      samp_q   <= samp_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
      valid_q  <= valid_d;
      value_q  <= value_d;
      err_q    <= err_d;
      filled_q <= filled_d;
      ovr_q    <= ovr_d;
    end
  end

  assign valid    = valid_q;
  assign value    = value_q;
  assign err_mask = err_q;
  assign error    = |err_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_hex_segment_decoder.sv
// Random and directed stimulus for hex_segment_decoder; a monitor process
// drains a queue of expected words whenever the DUT presents one.
module tb_hex_segment_decoder;

  typedef struct packed {
    logic [23:0] v;
    logic [5:0]  e;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic [5:0]  digit_sel;
  logic        ready;
  logic        valid;
  logic [23:0] value;
  logic [5:0]  err_mask;
  logic        error;
  logic        overrun;

  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   nexp = 0;
  bit   rdy_force = 1'b0;
  bit   rdy_val = 1'b0;
  exp_t q[$];

  logic [23:0] m_val = '0;
  logic [5:0]  m_err = '0;

  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                           7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  hex_segment_decoder dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .digit_sel(digit_sel),
    .ready(ready), .valid(valid), .value(value), .err_mask(err_mask),
    .error(error), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_dec(input logic [6:0] s);
    for (int i = 0; i < 16; i++)
      if (pat[i] == s) return {1'b1, 4'(i)};
    return 5'd0;
  endfunction

  function automatic logic [6:0] gen_bad();
    logic [6:0] s;
    logic [4:0] d;
    do begin
      s = 7'($urandom_range(0, 127));
      d = ref_dec(s);
    end while (d[4] || s == 7'h7F);
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] sel, input logic [6:0] s,
                       input int n);
    digit_sel = sel;
    seg_in    = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic present(input int k, input logic [6:0] s, input int n,
                         input bit last);
    logic [4:0] d;
    d = ref_dec(s);
    m_val[4*k +: 4] = d[4] ? d[3:0] : 4'h0;
    m_err[k] = ~d[4];
    if (last) begin
      q.push_back('{v: m_val, e: m_err});
      nexp++;
    end
    drive(6'(1) << k, s, n);
    drive('0, 7'h7F, 1);
  endtask

  task automatic wait_acc();
    int n = 0;
    while (acc_cnt < nexp && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("word_accepted", 32'(acc_cnt), 32'(nexp));
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("valid_rise", {31'd0, valid}, 32'd1);
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_valid"}, {31'd0, valid}, 32'd0);
    check({nm, "_value"}, {8'd0, value}, 32'd0);
    check({nm, "_err"}, {26'd0, err_mask}, 32'd0);
    check({nm, "_error"}, {31'd0, error}, 32'd0);
    check({nm, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  // Monitor: decides ready, then checks the presented word.
  initial begin
    ready = 1'b0;
    forever begin
      @(negedge clk);
      ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
      if (reset && valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got value %h want no word", value);
        end else begin
          check("word_value", {8'd0, value}, {8'd0, q[0].v});
          check("word_err", {26'd0, err_mask}, {26'd0, q[0].e});
          check("word_error", {31'd0, error}, {31'd0, |q[0].e});
          if (ready) begin
            void'(q.pop_front());
            acc_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    seg_in    = 7'h7F;
    digit_sel = '0;
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // digit k shows k+1 with ready tied high
    rdy_force = 1'b1;
    rdy_val   = 1'b1;
    for (int k = 0; k < 6; k++) present(k, pat[k+1], 6, k == 5);
    wait_acc();
    @(negedge clk);
    check("valid_one_cycle", {31'd0, valid}, 32'd0);
    check("word1_model", {8'd0, m_val}, 32'h654321);
    rdy_force = 1'b0;

    // short run on digit 0 must not capture
    for (int k = 1; k < 6; k++) present(k, pat[k+9], 5, 1'b0);
    drive(6'b000001, 7'h79, 3);
    drive(6'b000010, 7'h79, 1);
    drive('0, 7'h7F, 6);
    check("short_run_no_word", {31'd0, valid}, 32'd0);
    present(0, pat[7], 5, 1'b1);
    wait_acc();

    // undecodable pattern on digit 2
    for (int k = 0; k < 6; k++)
      present(k, (k == 2) ? 7'h7E : pat[k+3], 4 + k % 3, k == 5);
    wait_acc();

    // overrun while word is held
    rdy_force = 1'b1;
    rdy_val   = 1'b0;
    for (int k = 0; k < 6; k++) present(k, pat[15-k], 5, k == 5);
    wait_valid();
    drive(6'b000001, pat[9], 10);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    check("hold_value", {8'd0, value}, {8'd0, m_val});
    check("hold_valid", {31'd0, valid}, 32'd1);
    rdy_val = 1'b1;
    drive(6'b000001, pat[9], 3);
    check("release_valid", {31'd0, valid}, 32'd0);
    check("release_overrun", {31'd0, overrun}, 32'd0);
    drive('0, 7'h7F, 1);
    wait_acc();
    rdy_force = 1'b0;

    // reset mid-collection
    for (int k = 0; k < 3; k++) present(k, pat[k+4], 5, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outs("midreset");
    @(negedge clk);
    reset = 1'b1;
    m_val = '0;
    m_err = '0;
    for (int k = 0; k < 5; k++) present(k, pat[k+8], 5, 1'b0);
    drive('0, 7'h7F, 6);
    check("need_full_word", {31'd0, valid}, 32'd0);
    present(5, pat[2], 5, 1'b1);
    wait_acc();

    // unqualified codes, then latest rewrite wins
    for (int k = 0; k < 5; k++) present(k, pat[k], 5, 1'b0);
    drive(6'b000011, pat[5], 10);
    drive(6'b000000, pat[5], 10);
    drive(6'b100000, 7'h7F, 10);
    check("ignored_codes", {31'd0, valid}, 32'd0);
    present(1, 7'h24, 6, 1'b0);
    present(1, 7'h30, 6, 1'b0);
    check("rewrite_model", {28'd0, m_val[7:4]}, 32'd3);
    present(5, pat[6], 6, 1'b1);
    wait_acc();

    // randomized words with glitches and rewrites
    for (int w = 0; w < 25; w++) begin
      int ord[6];
      int nx;
      int t;
      for (int i = 0; i < 6; i++) ord[i] = i;
      for (int i = 5; i > 0; i--) begin
        int j;
        j = $urandom_range(0, i);
        t = ord[i];
        ord[i] = ord[j];
        ord[j] = t;
      end
      nx = $urandom_range(0, 3);
      for (int p = 0; p < 6 + nx; p++) begin
        int k;
        logic [6:0] s;
        logic [5:0] gs;
        if (p < 5) k = ord[p];
        else if (p < 5 + nx) k = ord[$urandom_range(0, 4)];
        else k = ord[5];
        s = ($urandom_range(0, 9) == 0) ? gen_bad() : pat[$urandom_range(0, 15)];
        if ($urandom_range(0, 3) == 0) begin
          drive(6'($urandom), 7'($urandom), $urandom_range(1, 3));
          drive('0, 7'h7F, 1);
        end
        if ($urandom_range(0, 9) == 0) begin
          gs = 6'($urandom);
          if ($countones(gs) == 1) gs = '0;
          drive(gs, pat[$urandom_range(0, 15)], 8);
          drive('0, 7'h7F, 1);
        end
        present(k, s, 4 + $urandom_range(0, 3), p == 5 + nx);
      end
      wait_acc();
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
